// File: rtl/operand_loader.sv
// Operand entry unit: assembles NUM_OPS operands of DATA_W bits from IN_W-bit
// switch chunks, one per debounced button press, and drives a 4-digit hex display.
module operand_loader #(
    parameter int unsigned  DATA_W  = 32,
    parameter int unsigned  IN_W    = 8,
    parameter int unsigned  NUM_OPS = 2,
    localparam int unsigned CHUNKS  = DATA_W / IN_W,
    localparam int unsigned SEL_W   = $clog2(NUM_OPS + 1),
    localparam int unsigned CIDX_W  = $clog2(CHUNKS) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic [IN_W-1:0]           inputdata,
    input  logic                      loaddata,
    input  logic [DATA_W-1:0]         dataR,
    input  logic [SEL_W-1:0]          disp_sel,
    input  logic                      disp_half,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      inputdata_ready,
    output logic                      busy,
    output logic [SEL_W-1:0]          op_idx,
    output logic [CIDX_W-1:0]         chunk_idx,
    output logic [6:0]                disp3,
    output logic [6:0]                disp2,
    output logic [6:0]                disp1,
    output logic [6:0]                disp0
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

    state_t state_q, state_d;
    logic   enter_s1, enter_s2, enter_d, press_q;
    logic   wr_c, clr_idx_c, last_c;

    // Two-flop synchroniser, edge detect, and a registered single-cycle press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enter_s1 <= 1'b0;
            enter_s2 <= 1'b0;
            enter_d  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            enter_s1 <= enter;
            enter_s2 <= enter_s1;
            enter_d  <= enter_s2;
            press_q  <= enter_s2 & ~enter_d;
        end
    end

    assign last_c = (chunk_idx == CIDX_W'(CHUNKS - 1)) && (op_idx == SEL_W'(NUM_OPS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (loaddata) state_d = LOAD;
            LOAD:    if (!loaddata) state_d = IDLE;
                     else if (press_q && last_c) state_d = DONE;
            DONE:    if (!loaddata) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over a coincident press, so the write is gated by loaddata
    always_comb begin
        wr_c      = 1'b0;
        clr_idx_c = 1'b0;
        case (state_q)
            IDLE:    clr_idx_c = 1'b1;
            LOAD:    if (!loaddata) clr_idx_c = 1'b1;
                     else if (press_q) wr_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            operands        <= '0;
            op_idx          <= '0;
            chunk_idx       <= '0;
            busy            <= 1'b0;
            inputdata_ready <= 1'b0;
        end else begin
            busy            <= (state_d == LOAD);
            inputdata_ready <= wr_c & last_c;
            for (int unsigned k = 0; k < NUM_OPS; k++) begin
                for (int unsigned c = 0; c < CHUNKS; c++) begin
                    if (wr_c && op_idx == SEL_W'(k) && chunk_idx == CIDX_W'(c))
                        operands[k*DATA_W + c*IN_W +: IN_W] <= inputdata;
                end
            end
            if (clr_idx_c) begin
                op_idx    <= '0;
                chunk_idx <= '0;
            end else if (wr_c) begin
                if (last_c) begin
                    op_idx    <= '0;
                    chunk_idx <= '0;
                end else if (chunk_idx == CIDX_W'(CHUNKS - 1)) begin
                    op_idx    <= op_idx + SEL_W'(1);
                    chunk_idx <= '0;
                end else begin
                    chunk_idx <= chunk_idx + CIDX_W'(1);
                end
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [DATA_W-1:0] src_c;
    logic [31:0]       src32_c;
    logic [15:0]       slice_c;
    logic              blank_c;

    // Display source mux; bits beyond DATA_W read as zero
    always_comb begin
        src_c   = dataR;
        blank_c = (disp_sel > SEL_W'(NUM_OPS));
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            if (disp_sel == SEL_W'(k)) src_c = operands[k*DATA_W +: DATA_W];
        end
        src32_c = 32'(src_c);
        slice_c = disp_half ? src32_c[31:16] : src32_c[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp3 <= 7'b1000000;
            disp2 <= 7'b1000000;
            disp1 <= 7'b1000000;
            disp0 <= 7'b1000000;
        end else if (blank_c) begin
            disp3 <= 7'b1111111;
            disp2 <= 7'b1111111;
            disp1 <= 7'b1111111;
            disp0 <= 7'b1111111;
        end else begin
            disp3 <= hex7(slice_c[15:12]);
            disp2 <= hex7(slice_c[11:8]);
            disp1 <= hex7(slice_c[7:4]);
            disp0 <= hex7(slice_c[3:0]);
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: two configurations (2x32/8 and 3x16/4) driven in
// parallel and checked every cycle against a position-counter reference model.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        reset, enter, loaddata, disp_half;
    logic [7:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] dr_a;
    logic [1:0]  sel;

    logic [63:0] ops_a;
    logic        rdy_a, busy_a;
    logic [1:0]  opi_a;
    logic [2:0]  chi_a;
    logic [6:0]  d3a, d2a, d1a, d0a;

    logic [47:0] ops_b;
    logic        rdy_b, busy_b;
    logic [1:0]  opi_b;
    logic [2:0]  chi_b;
    logic [6:0]  d3b, d2b, d1b, d0b;

    int n_cmp = 0, n_fail = 0;
    int rdy_cnt_a = 0, rdy_cnt_b = 0;

    always #5 clk = ~clk;

    operand_loader dut_a (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(in_a), .loaddata(loaddata),
        .dataR(dr_a), .disp_sel(sel), .disp_half(disp_half), .operands(ops_a),
        .inputdata_ready(rdy_a), .busy(busy_a), .op_idx(opi_a), .chunk_idx(chi_a),
        .disp3(d3a), .disp2(d2a), .disp1(d1a), .disp0(d0a)
    );

    operand_loader #(.DATA_W(16), .IN_W(4), .NUM_OPS(3)) dut_b (
        .clk(clk), .reset(reset), .enter(enter), .inputdata(in_b), .loaddata(loaddata),
        .dataR(dr_a[15:0]), .disp_sel(sel), .disp_half(disp_half), .operands(ops_b),
        .inputdata_ready(rdy_b), .busy(busy_b), .op_idx(opi_b), .chunk_idx(chi_b),
        .disp3(d3b), .disp2(d2b), .disp1(d1b), .disp0(d0b)
    );

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
        endcase
    endfunction

    // Reference model: mode 0 idle, 1 loading, 2 done; pos is the linear chunk count
    int          m_mode [2];
    int          m_pos  [2];
    bit   [3:0]  m_hist [2];
    logic [31:0] m_ops  [2][3];
    bit          m_rdy  [2];
    logic [6:0]  m_disp [2][4];

    task automatic m_reset(input int i);
        m_mode[i] = 0;
        m_pos[i]  = 0;
        m_hist[i] = 4'b0;
        m_rdy[i]  = 1'b0;
        for (int k = 0; k < 3; k++) m_ops[i][k] = 32'd0;
        for (int d = 0; d < 4; d++) m_disp[i][d] = seg(4'h0);
    endtask

    task automatic m_step(input int i, input int nops, input int dw, input int iw,
                          input logic [31:0] din, input logic [31:0] dr);
        int          chunks, op, c;
        logic [31:0] v, dmask, imask;
        bit          press;
        chunks = dw / iw;
        dmask  = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        v      = (int'(sel) < nops) ? m_ops[i][int'(sel)] : (dr & dmask);
        if (disp_half) v = v >> 16;
        for (int d = 0; d < 4; d++)
            m_disp[i][d] = (int'(sel) > nops) ? 7'b1111111 : seg(4'((v >> (4 * d)) & 32'hF));
        // a press reaches the write stage three edges after the first high sample
        press     = m_hist[i][2] && !m_hist[i][3];
        m_hist[i] = {m_hist[i][2:0], enter};
        m_rdy[i]  = 1'b0;
        case (m_mode[i])
            0: if (loaddata) begin m_mode[i] = 1; m_pos[i] = 0; end
            1: if (!loaddata) begin
                   m_mode[i] = 0; m_pos[i] = 0;
               end else if (press) begin
                   imask = (32'd1 << iw) - 32'd1;
                   op = m_pos[i] / chunks;
                   c  = m_pos[i] % chunks;
                   m_ops[i][op] = (m_ops[i][op] & ~(imask << (c * iw))) | ((din & imask) << (c * iw));
                   m_pos[i]++;
                   if (m_pos[i] == nops * chunks) begin
                       m_mode[i] = 2; m_pos[i] = 0; m_rdy[i] = 1'b1;
                   end
               end
            default: if (!loaddata) m_mode[i] = 0;
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(posedge clk) begin
        if (reset) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, 2, 32, 8, 32'(in_a), dr_a);
            m_step(1, 3, 16, 4, 32'(in_b), 32'(dr_a[15:0]));
        end
        #1;
        if (rdy_a === 1'b1) rdy_cnt_a++;
        if (rdy_b === 1'b1) rdy_cnt_b++;
        for (int k = 0; k < 2; k++) chk($sformatf("a_op%0d", k), 64'(ops_a[k*32 +: 32]), 64'(m_ops[0][k]));
        for (int k = 0; k < 3; k++) chk($sformatf("b_op%0d", k), 64'(ops_b[k*16 +: 16]), 64'(m_ops[1][k][15:0]));
        chk("a_ready", 64'(rdy_a), 64'(m_rdy[0]));
        chk("b_ready", 64'(rdy_b), 64'(m_rdy[1]));
        chk("a_busy", 64'(busy_a), 64'(m_mode[0] == 1));
        chk("b_busy", 64'(busy_b), 64'(m_mode[1] == 1));
        chk("a_op_idx", 64'(opi_a), 64'(m_pos[0] / 4));
        chk("a_chunk_idx", 64'(chi_a), 64'(m_pos[0] % 4));
        chk("b_op_idx", 64'(opi_b), 64'(m_pos[1] / 4));
        chk("b_chunk_idx", 64'(chi_b), 64'(m_pos[1] % 4));
        chk("a_disp", 64'({d3a, d2a, d1a, d0a}),
            64'({m_disp[0][3], m_disp[0][2], m_disp[0][1], m_disp[0][0]}));
        chk("b_disp", 64'({d3b, d2b, d1b, d0b}),
            64'({m_disp[1][3], m_disp[1][2], m_disp[1][1], m_disp[1][0]}));
    end

    task automatic press(input logic [7:0] va, input logic [3:0] vb, input int hold, input int gap);
        in_a  = va;
        in_b  = vb;
        enter = 1'b1;
        repeat (hold) @(negedge clk);
        enter = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; loaddata = 1'b0; disp_half = 1'b0;
        in_a = 8'd0; in_b = 4'd0; dr_a = 32'd0; sel = 2'd0;
        m_reset(0); m_reset(1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_ops", ops_a, 64'd0);
        chk("lit_reset_disp", 64'({d3a, d0a}), 64'({7'b1000000, 7'b1000000}));

        // full sessions: A completes on press 8, B on press 12
        loaddata = 1'b1;
        @(negedge clk);
        rdy_cnt_a = 0; rdy_cnt_b = 0;
        for (int i = 0; i < 12; i++) press(8'(8'h11 * (i + 1)), 4'(i + 1), 2, 4);
        repeat (4) @(negedge clk);
        chk("lit_a_op0", 64'(ops_a[31:0]), 64'h4433_2211);
        chk("lit_a_op1", 64'(ops_a[63:32]), 64'h8877_6655);
        chk("lit_a_ready_cnt", 64'(rdy_cnt_a), 64'd1);
        chk("lit_a_busy_end", 64'(busy_a), 64'd0);
        chk("lit_b_ops", 64'(ops_b), 64'hCBA9_8765_4321);
        chk("lit_b_ready_cnt", 64'(rdy_cnt_b), 64'd1);

        sel = 2'd0; disp_half = 1'b1;
        @(negedge clk);
        chk("lit_disp_4433", 64'({d3a, d2a, d1a, d0a}),
            64'({7'b0011001, 7'b0011001, 7'b0110000, 7'b0110000}));
        sel = 2'd2; disp_half = 1'b0; dr_a = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_disp_beef", 64'({d3a, d2a, d1a, d0a}),
            64'({7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110}));
        sel = 2'd3;
        @(negedge clk);
        chk("lit_disp_blank", 64'({d3a, d0a}), 64'({7'b1111111, 7'b1111111}));
        chk("lit_b_disp_dataR", 64'(d3b), 64'(7'b0000011));

        // reset mid-session clears everything at once
        loaddata = 1'b0;
        repeat (2) @(negedge clk);
        loaddata = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) press(8'(8'hF0 + i), 4'(i), 2, 4);
        reset = 1'b1;
        #1;
        chk("lit_async_ops", ops_a, 64'd0);
        chk("lit_async_disp", 64'({d3a, d0a}), 64'({7'b1000000, 7'b1000000}));
        @(negedge clk);
        reset = 1'b0;
        sel = 2'd0;
        @(negedge clk);
        chk("lit_restart_busy", 64'(busy_a), 64'd1);
        chk("lit_restart_chunk", 64'(chi_a), 64'd0);

        // abort coincident with the write of a 4th press
        rdy_cnt_a = 0;
        for (int i = 0; i < 3; i++) press(8'(8'h11 * (i + 1)), 4'(i + 1), 2, 4);
        in_a = 8'h44; enter = 1'b1;
        repeat (3) @(negedge clk);
        loaddata = 1'b0;
        @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_abort_op0", 64'(ops_a[31:0]), 64'h0033_2211);
        chk("lit_abort_idx", 64'({opi_a, chi_a}), 64'd0);
        chk("lit_abort_ready", 64'(rdy_cnt_a), 64'd0);
        loaddata = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) press(8'(8'hA1 + i), 4'(i), 1, 5);
        repeat (4) @(negedge clk);
        chk("lit_reload", ops_a, 64'hA8A7_A6A5_A4A3_A2A1);
        chk("lit_reload_ready", 64'(rdy_cnt_a), 64'd1);

        // one long hold writes a single chunk
        pulse_reset();
        loaddata = 1'b1;
        @(negedge clk);
        press(8'h5A, 4'hA, 50, 5);
        chk("lit_hold_chunk_idx", 64'(chi_a), 64'd1);
        chk("lit_hold_ops", ops_a, 64'h5A);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            sel       = 2'($urandom_range(0, 3));
            disp_half = 1'($urandom_range(0, 1));
            dr_a      = $urandom;
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else if ($urandom_range(0, 9) == 0) begin
                loaddata = ~loaddata;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end else
                press(8'($urandom), 4'($urandom), $urandom_range(1, 6), $urandom_range(1, 5));
        end
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
